// File: rtl/mmio_req_pkg.sv
// mmio_req_pkg: shared state encoding, AFU register map and timeout pattern
package mmio_req_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} t_mmio_req_state;
  localparam logic [15:0] DFH      = 16'h0000;
  localparam logic [15:0] AFU_ID_L = 16'h0002;
  localparam logic [15:0] AFU_ID_H = 16'h0004;
  localparam logic [15:0] POLY     = 16'h0010;
  localparam logic [15:0] LFSR     = 16'h0012;
  localparam logic [15:0] CTRL     = 16'h0014;
  localparam logic [63:0] TIMEOUT_PATTERN = '1;
endpackage

// File: rtl/mmio_requester.sv
// mmio_requester: turns a command stream into MMIO request pulses and
// returns TID-matched read data (or a timeout marker) on a valid/ready port.
module mmio_requester
  import mmio_req_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 64,
  parameter int TID_W   = 9,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              mmio_wr_valid,
  output logic              mmio_rd_valid,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [TID_W-1:0]  mmio_tid,
  output logic [DATA_W-1:0] mmio_data,
  input  logic              afu_rd_valid,
  input  logic [TID_W-1:0]  afu_tid,
  input  logic [DATA_W-1:0] afu_data,
  output logic              busy
);
  localparam int CNT_W = $clog2(TIMEOUT);
  t_mmio_req_state  r_state;
  logic [TID_W-1:0] r_tid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_match;
  // mmio_tid still holds the TID of the outstanding read while waiting
  assign w_match = afu_rd_valid && afu_tid == mmio_tid;
  assign busy = r_state != ST_IDLE;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_tid         <= '0;
      r_cnt         <= '0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_timeout   <= 1'b0;
      mmio_wr_valid <= 1'b0;
      mmio_rd_valid <= 1'b0;
      mmio_addr     <= '0;
      mmio_tid      <= '0;
      mmio_data     <= '0;
    end else begin
      mmio_wr_valid <= 1'b0;
      mmio_rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready     <= 1'b0;
            mmio_addr     <= cmd_addr;
            mmio_data     <= cmd_wdata;
            mmio_tid      <= r_tid;
            mmio_wr_valid <= cmd_write;
            mmio_rd_valid <= !cmd_write;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_tid     <= r_tid + 1'b1;
          r_cnt     <= '0;
          cmd_ready <= mmio_wr_valid;
          r_state   <= mmio_wr_valid ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // a match on the final count still wins over the timeout
          if (w_match) begin
            rsp_data    <= afu_data;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            r_state     <= ST_RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_data    <= DATA_W'(TIMEOUT_PATTERN);
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_requester.sv
// tb_mmio_requester: directed and randomized transactions against a
// transaction-level model (expected TID sequence, expected read result).
module tb_mmio_requester;
  import mmio_req_pkg::*;
  localparam int TO = 16;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        afu_rd_valid = 1'b0;
  logic [8:0]  afu_tid = '0;
  logic [63:0] afu_data = '0;
  logic        cmd_ready, rsp_valid, rsp_timeout, mmio_wr_valid, mmio_rd_valid, busy;
  logic [63:0] rsp_data, mmio_data;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  int checks = 0, failures = 0, exp_tid = 0;
  logic [15:0] regs [6] = '{DFH, AFU_ID_L, AFU_ID_H, POLY, LFSR, CTRL};

  always #5 clock = ~clock;

  mmio_requester #(.ADDR_W(16), .DATA_W(64), .TID_W(9), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_data(mmio_data),
    .afu_rd_valid(afu_rd_valid), .afu_tid(afu_tid), .afu_data(afu_data), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 40 && cmd_ready !== 1'b1; i++) step();
    chk("cmd_ready_bound", cmd_ready, 1);
  endtask

  task automatic issue(input bit wr, input logic [15:0] a, input logic [63:0] d);
    wait_ready();
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
    chk("wr_pulse", mmio_wr_valid, 64'(wr));
    chk("rd_pulse", mmio_rd_valid, 64'(!wr));
    chk("req_addr", mmio_addr, a);
    chk("req_tid", mmio_tid, 64'(exp_tid));
    if (wr) chk("req_wdata", mmio_data, d);
    chk("issue_busy", busy, 1);
    chk("issue_ready", cmd_ready, 0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [63:0] d);
    issue(1'b1, a, d);
    exp_tid = (exp_tid + 1) % 512;
    step();
    chk("wr_one_cycle", mmio_wr_valid, 0);
    chk("wr_ready_back", cmd_ready, 1);
  endtask

  // delay: negedges after the request pulse at which the correct response is driven
  task automatic do_read(input logic [15:0] a, input logic [63:0] d, input int delay,
                         input bit wrong_first, input bit respond, input int hold);
    logic [8:0]  t;
    logic [63:0] exp_d;
    int          el;
    issue(1'b0, a, '0);
    t = 9'(exp_tid);
    exp_tid = (exp_tid + 1) % 512;
    step();
    el = 1;
    chk("rd_one_cycle", mmio_rd_valid, 0);
    if (wrong_first) begin
      afu_rd_valid = 1'b1; afu_tid = t ^ 9'($urandom_range(1, 511)); afu_data = ~d;
      step();
      el++;
      afu_rd_valid = 1'b0;
      chk("wrong_tid_ignored", rsp_valid, 0);
    end
    if (respond) begin
      while (el < delay) begin step(); el++; end
      afu_rd_valid = 1'b1; afu_tid = t; afu_data = d;
      step();
      afu_rd_valid = 1'b0;
      exp_d = d;
    end else begin
      while (el < TO) begin step(); el++; end
      chk("no_early_timeout", rsp_valid, 0);
      step();
      exp_d = '1;
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_timeout", rsp_timeout, 64'(!respond));
    chk("resp_ready_low", cmd_ready, 0);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = 16'($urandom);
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, exp_d);
      chk("hold_timeout", rsp_timeout, 64'(!respond));
      chk("hold_ready_low", cmd_ready, 0);
      chk("hold_no_issue", {mmio_wr_valid, mmio_rd_valid}, 0);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_ready", cmd_ready, 1);
    chk("post_hs_busy", busy, 0);
    if (!respond) begin
      afu_rd_valid = 1'b1; afu_tid = t; afu_data = 64'h1234;
      step();
      afu_rd_valid = 1'b0;
      chk("late_rsp_ignored", rsp_valid, 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {cmd_ready, rsp_valid, rsp_timeout, mmio_wr_valid, mmio_rd_valid, busy}, 0);
    chk({tag, "_rdata"}, rsp_data, 0);
    chk({tag, "_wdata"}, mmio_data, 0);
    chk({tag, "_addr"}, mmio_addr, 0);
    chk({tag, "_tid"}, mmio_tid, 0);
  endtask

  initial begin
    bit wf, rs;
    #1 reset_n = 1'b0;
    step(); step();
    chk_all_zero("reset");
    reset_n = 1'b1;
    step();
    do_write(POLY, 64'h8000_0057);
    do_read(DFH, 64'h1000_0100_0000_0000, 2, 1'b0, 1'b1, 0);
    do_read(LFSR, {$urandom, $urandom}, 5, 1'b1, 1'b1, 0);
    do_read(CTRL, '0, 0, 1'b0, 1'b0, 0);
    do_read(AFU_ID_L, {$urandom, $urandom}, TO, 1'b0, 1'b1, 0);
    do_read(AFU_ID_H, {$urandom, $urandom}, 3, 1'b0, 1'b1, 5);
    do_read(POLY, '0, 0, 1'b1, 1'b0, 5);
    // reset in the middle of a read: outputs clear at once, TID restarts
    issue(1'b0, LFSR, '0);
    step(); step();
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    step();
    reset_n = 1'b1;
    exp_tid = 0;
    step();
    chk("after_reset_ready", cmd_ready, 1);
    for (int i = 0; i < 513; i++) do_write(regs[i % 6], {$urandom, $urandom});
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(regs[$urandom_range(0, 5)], {$urandom, $urandom});
      else begin
        wf = 1'($urandom);
        rs = $urandom_range(0, 3) != 0;
        do_read(16'($urandom), {$urandom, $urandom}, $urandom_range(wf ? 3 : 1, TO), wf, rs,
                $urandom_range(0, 3));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
